// File: rtl/glitch_seq.sv
// Multi-channel, multi-pulse glitch sequencer with a byte-lane register port.
// Timing config is copied to shadow registers at arm so a run is immune to host reprogramming.
module glitch_seq #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned RPT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [7:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  output logic [7:0]        cfg_rdata,
  input  logic              arm,
  input  logic              disarm,
  input  logic              i_trig,
  output logic [NUM_CH-1:0] o_glitch,
  output logic [2:0]        o_state,
  output logic              o_done,
  output logic [RPT_W-1:0]  o_fire_count
);
  localparam int unsigned CNT_LANES = CNT_W / 8;
  localparam int unsigned RPT_LANES = RPT_W / 8;
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARMED = 3'd1, S_WAIT = 3'd2, S_FIRE = 3'd3, S_GAP = 3'd4, S_DONE = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  delay_q, delay_d, width_q, width_d, gap_q, gap_d;
  logic [RPT_W-1:0]  repeat_q, repeat_d;
  logic [NUM_CH-1:0] chmask_q, chmask_d;
  logic [2:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  sh_delay_q, sh_width_q, sh_gap_q;
  logic [RPT_W-1:0]  sh_repeat_q;
  logic [NUM_CH-1:0] sh_chmask_q;
  logic [2:0]        sh_mode_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RPT_W-1:0]  pulse_q, pulse_d, fire_q, fire_d;
  logic [CH_W-1:0]   cur_q, cur_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [NUM_CH-1:0] glitch_q, glitch_d;
  logic              done_q, done_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [3:0]        reg_id, lane;
  logic [CNT_W-1:0]  cnt_word, delay_last, width_last, gap_last;
  logic              swtrig, act_now, act_prev, trig_evt, arm_acc;

  assign reg_id = cfg_addr[7:4];
  assign lane   = cfg_addr[3:0];
  assign swtrig = cfg_we && (reg_id == 4'd6);

  // Next set bit of mask strictly after cur, wrapping; used for round-robin channel rotation.
  function automatic logic [CH_W-1:0] next_set(input logic [NUM_CH-1:0] mask,
                                               input logic [CH_W-1:0] cur);
    logic [CH_W-1:0] res;
    logic            found;
    int unsigned     idx;
    res   = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = 32'(cur) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (!found && (idx == j) && mask[j]) begin
          res   = CH_W'(j);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  always_comb begin : cfg_write
    delay_d  = delay_q;
    width_d  = width_q;
    gap_d    = gap_q;
    repeat_d = repeat_q;
    chmask_d = chmask_q;
    mode_d   = mode_q;
    if (cfg_we) begin
      for (int unsigned l = 0; l < CNT_LANES; l++) begin
        if (lane == 4'(l)) begin
          if (reg_id == 4'd0) delay_d[8*l +: 8] = cfg_wdata;
          if (reg_id == 4'd1) width_d[8*l +: 8] = cfg_wdata;
          if (reg_id == 4'd2) gap_d[8*l +: 8]   = cfg_wdata;
        end
      end
      for (int unsigned l = 0; l < RPT_LANES; l++) begin
        if (lane == 4'(l) && reg_id == 4'd3) repeat_d[8*l +: 8] = cfg_wdata;
      end
      if (lane == 4'd0 && reg_id == 4'd4) chmask_d = cfg_wdata[NUM_CH-1:0];
      if (lane == 4'd0 && reg_id == 4'd5) mode_d   = cfg_wdata[2:0];
    end
  end

  always_comb begin : cfg_read
    rdata_d  = 8'hFF;
    cnt_word = (reg_id == 4'd0) ? delay_q : (reg_id == 4'd1) ? width_q : gap_q;
    case (reg_id)
      4'd0, 4'd1, 4'd2: begin
        for (int unsigned l = 0; l < CNT_LANES; l++)
          if (lane == 4'(l)) rdata_d = cnt_word[8*l +: 8];
      end
      4'd3: begin
        for (int unsigned l = 0; l < RPT_LANES; l++)
          if (lane == 4'(l)) rdata_d = repeat_q[8*l +: 8];
      end
      4'd4: if (lane == 4'd0) rdata_d = 8'(chmask_q);
      4'd5: if (lane == 4'd0) rdata_d = {5'b0, mode_q};
      4'd6: rdata_d = 8'h00;
      4'd7: begin
        if (lane == 4'd0) rdata_d = {5'b0, state_q};
        for (int unsigned l = 1; l <= RPT_LANES; l++)
          if (lane == 4'(l)) rdata_d = fire_q[8*(l-1) +: 8];
      end
      default: ;
    endcase
  end

  // Trigger qualification uses the polarity/edge settings captured at arm.
  assign act_now    = sync2_q ^ sh_mode_q[1];
  assign act_prev   = prev_q ^ sh_mode_q[1];
  assign trig_evt   = swtrig || (sh_mode_q[0] ? (act_now && !act_prev) : act_now);
  assign arm_acc    = arm && !disarm && (state_q == S_IDLE || state_q == S_DONE);
  assign delay_last = sh_delay_q - CNT_W'(1);
  assign width_last = (sh_width_q == '0) ? '0 : sh_width_q - CNT_W'(1);
  assign gap_last   = (sh_gap_q == '0) ? '0 : sh_gap_q - CNT_W'(1);

  always_ff @(posedge clk) begin : fsm_state
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: if (trig_evt) state_d = (sh_delay_q == '0) ? S_FIRE : S_WAIT;
      S_WAIT:  if (cnt_q == delay_last) state_d = S_FIRE;
      S_FIRE:  if (cnt_q == width_last) state_d = (pulse_q == sh_repeat_q) ? S_DONE : S_GAP;
      S_GAP:   if (cnt_q == gap_last) state_d = S_FIRE;
      S_DONE:  state_d = arm ? S_ARMED : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (disarm) state_d = S_IDLE;
  end

  always_comb begin : fsm_out
    glitch_d = '0;
    if (state_d == S_FIRE) begin
      if (sh_mode_q[2]) begin
        for (int unsigned j = 0; j < NUM_CH; j++)
          glitch_d[j] = sh_chmask_q[j] && (cur_d == CH_W'(j));
      end else begin
        glitch_d = sh_chmask_q;
      end
    end
    done_d = (state_d == S_DONE);
  end

  always_comb begin : datapath
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    fire_d  = fire_q;
    cur_d   = cur_q;
    if (state_d != state_q) cnt_d = '0;
    else if (state_q inside {S_WAIT, S_FIRE, S_GAP}) cnt_d = cnt_q + CNT_W'(1);
    if (arm_acc) begin
      pulse_d = '0;
      fire_d  = '0;
      cur_d   = next_set(chmask_q, CH_W'(NUM_CH - 1));
    end
    if (state_d == S_FIRE && state_q != S_FIRE) fire_d = fire_q + RPT_W'(1);
    if (state_q == S_FIRE && state_d == S_GAP) begin
      pulse_d = pulse_q + RPT_W'(1);
      cur_d   = next_set(sh_chmask_q, cur_q);
    end
  end

  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      delay_q <= '0; width_q <= '0; gap_q <= '0; repeat_q <= '0; chmask_q <= '0; mode_q <= '0;
      sh_delay_q <= '0; sh_width_q <= '0; sh_gap_q <= '0; sh_repeat_q <= '0;
      sh_chmask_q <= '0; sh_mode_q <= '0;
      cnt_q <= '0; pulse_q <= '0; fire_q <= '0; cur_q <= '0;
      sync1_q <= 1'b0; sync2_q <= 1'b0; prev_q <= 1'b0;
      glitch_q <= '0; done_q <= 1'b0; rdata_q <= '0;
    end else begin
      delay_q <= delay_d; width_q <= width_d; gap_q <= gap_d;
      repeat_q <= repeat_d; chmask_q <= chmask_d; mode_q <= mode_d;
      if (arm_acc) begin
        sh_delay_q <= delay_q; sh_width_q <= width_q; sh_gap_q <= gap_q;
        sh_repeat_q <= repeat_q; sh_chmask_q <= chmask_q; sh_mode_q <= mode_q;
      end
      cnt_q <= cnt_d; pulse_q <= pulse_d; fire_q <= fire_d; cur_q <= cur_d;
      sync1_q <= i_trig; sync2_q <= sync1_q; prev_q <= sync2_q;
      glitch_q <= glitch_d; done_q <= done_d;
      if (cfg_re) rdata_q <= rdata_d;
    end
  end

  assign cfg_rdata    = rdata_q;
  assign o_glitch     = glitch_q;
  assign o_state      = state_q;
  assign o_done       = done_q;
  assign o_fire_count = fire_q;
endmodule

// File: tb/tb_glitch_seq.sv
// Bench for glitch_seq: table of directed runs, randomized runs against a pulse-train model,
// and hand sequences for reprogramming, disarm, register reads and mid-run reset.
module tb_glitch_seq;
  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0, cfg_re = 1'b0, arm = 1'b0, disarm = 1'b0, i_trig = 1'b0;
  logic [7:0] cfg_addr = 8'h00, cfg_wdata = 8'h00;
  logic [7:0] cfg_rdata;
  logic [NCH-1:0] o_glitch;
  logic [2:0] o_state;
  logic       o_done;
  logic [15:0] o_fire_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int d; int w; int g; int r; int mask; int mode; int src;
    int exp_first; int exp_done; int exp_fc;
  } vec_t;

  glitch_seq #(.NUM_CH(NCH), .CNT_W(32), .RPT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .arm(arm), .disarm(disarm), .i_trig(i_trig),
    .o_glitch(o_glitch), .o_state(o_state), .o_done(o_done), .o_fire_count(o_fire_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [3:0] ln, input logic [7:0] data);
    cfg_we = 1'b1; cfg_addr = {id, ln}; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [3:0] ln, output int v);
    cfg_re = 1'b1; cfg_addr = {id, ln};
    tick();
    cfg_re = 1'b0;
    v = int'(cfg_rdata);
  endtask

  task automatic program_cfg(input vec_t v);
    for (int l = 0; l < 4; l++) begin
      wr(4'd0, 4'(l), 8'(v.d >> (8 * l)));
      wr(4'd1, 4'(l), 8'(v.w >> (8 * l)));
      wr(4'd2, 4'(l), 8'(v.g >> (8 * l)));
    end
    wr(4'd3, 4'd0, 8'(v.r));
    wr(4'd3, 4'd1, 8'(v.r >> 8));
    wr(4'd4, 4'd0, 8'(v.mask));
    wr(4'd5, 4'd0, 8'(v.mode));
  endtask

  function automatic int run_end(input vec_t v);
    int wp, gp;
    wp = (v.w == 0) ? 1 : v.w;
    gp = (v.g == 0) ? 1 : v.g;
    return 1 + v.d + v.r * (wp + gp) + wp;
  endfunction

  // Channel pattern of pulse k: whole mask, or k-th (mod popcount) set bit when rotating.
  function automatic int chan_of(input vec_t v, input int k);
    int pop, n;
    if (((v.mode >> 2) & 1) == 0) return v.mask;
    pop = 0;
    for (int i = 0; i < NCH; i++) pop += (v.mask >> i) & 1;
    if (pop == 0) return 0;
    n = k % pop;
    for (int i = 0; i < NCH; i++) begin
      if (((v.mask >> i) & 1) == 1) begin
        if (n == 0) return 1 << i;
        n--;
      end
    end
    return 0;
  endfunction

  // Expected outputs t cycles after the trigger event cycle.
  task automatic model(input vec_t v, input int t, output int g, output int st,
                       output int dn, output int fc);
    int wp, gp, per, s0, fin, rel;
    wp = (v.w == 0) ? 1 : v.w;
    gp = (v.g == 0) ? 1 : v.g;
    per = wp + gp; s0 = 1 + v.d; fin = run_end(v);
    g = 0; dn = 0;
    if (t < s0) begin
      st = 2; fc = 0;
    end else if (t < fin) begin
      rel = t - s0;
      fc = rel / per + 1;
      if (rel % per < wp) begin st = 3; g = chan_of(v, rel / per); end
      else st = 4;
    end else if (t == fin) begin
      st = 5; dn = 1; fc = v.r + 1;
    end else begin
      st = 0; fc = v.r + 1;
    end
  endtask

  // src: 0 = SWTRIG write, 1 = pin goes active after arm, 2 = pin already active at arm.
  task automatic run(input vec_t v, output int first, output int done_t);
    logic act;
    int e, g, st, dn, fc;
    program_cfg(v);
    act = (((v.mode >> 1) & 1) == 0);
    i_trig = (v.src == 2) ? act : ~act;
    repeat (3) tick();
    arm = 1'b1; tick(); arm = 1'b0;
    chk("armed_state", int'(o_state), 1);
    case (v.src)
      0: begin
        cfg_we = 1'b1; cfg_addr = 8'h60; cfg_wdata = 8'($urandom);
        e = cyc; tick(); cfg_we = 1'b0;
      end
      1: begin
        i_trig = act; e = cyc + 2; repeat (3) tick();
      end
      default: begin
        e = cyc; tick();
      end
    endcase
    first = 0; done_t = 0;
    for (int t = 1; t <= run_end(v) + 2; t++) begin
      model(v, t, g, st, dn, fc);
      chk("glitch", int'(o_glitch), g);
      chk("state", int'(o_state), st);
      chk("done", int'(o_done), dn);
      chk("fire_count", int'(o_fire_count), fc);
      if (first == 0 && o_glitch != '0) first = cyc - e;
      if (o_done) done_t = cyc - e;
      tick();
    end
  endtask

  task automatic sw_fire(output int e);
    cfg_we = 1'b1; cfg_addr = 8'h60; cfg_wdata = 8'h00;
    e = cyc; tick(); cfg_we = 1'b0;
  endtask

  task automatic wait_first(input int e, input int budget, output int t);
    int n;
    n = 0;
    while (o_glitch == '0 && n < budget) begin tick(); n++; end
    t = (o_glitch != '0) ? cyc - e : -1;
  endtask

  task automatic wait_done(input int budget, output int ok);
    int n;
    n = 0;
    while (!o_done && n < budget) begin tick(); n++; end
    ok = o_done ? 1 : 0;
    tick();
  endtask

  vec_t tbl[8];
  vec_t v;
  int first, done_t, rv, e, ok;

  initial begin
    tbl[0] = '{d:5, w:3, g:0, r:0, mask:1,  mode:1, src:1, exp_first:6, exp_done:9,  exp_fc:1};
    tbl[1] = '{d:0, w:2, g:4, r:2, mask:11, mode:4, src:0, exp_first:1, exp_done:15, exp_fc:3};
    tbl[2] = '{d:0, w:0, g:0, r:1, mask:15, mode:0, src:0, exp_first:1, exp_done:4,  exp_fc:2};
    tbl[3] = '{d:2, w:1, g:1, r:1, mask:0,  mode:0, src:0, exp_first:0, exp_done:6,  exp_fc:2};
    tbl[4] = '{d:1, w:1, g:2, r:3, mask:6,  mode:4, src:0, exp_first:2, exp_done:12, exp_fc:4};
    tbl[5] = '{d:3, w:2, g:1, r:1, mask:3,  mode:3, src:1, exp_first:4, exp_done:9,  exp_fc:2};
    tbl[6] = '{d:2, w:1, g:0, r:0, mask:4,  mode:0, src:2, exp_first:3, exp_done:4,  exp_fc:1};
    tbl[7] = '{d:0, w:1, g:0, r:0, mask:2,  mode:0, src:1, exp_first:1, exp_done:2,  exp_fc:1};

    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_glitch", int'(o_glitch), 0);
    chk("rst_state", int'(o_state), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_fire_count", int'(o_fire_count), 0);
    chk("rst_rdata", int'(cfg_rdata), 0);

    for (int i = 0; i < 8; i++) begin
      run(tbl[i], first, done_t);
      chk("tbl_first", first, tbl[i].exp_first);
      chk("tbl_done", done_t, tbl[i].exp_done);
      chk("tbl_fc", int'(o_fire_count), tbl[i].exp_fc);
    end

    rd(4'd7, 4'd1, rv); chk("status_lane1", rv, 1);
    rd(4'd7, 4'd2, rv); chk("status_lane2", rv, 0);
    rd(4'd7, 4'd3, rv); chk("status_lane3", rv, 8'hFF);
    rd(4'd0, 4'd7, rv); chk("delay_lane7", rv, 8'hFF);
    rd(4'd9, 4'd0, rv); chk("undef_id9", rv, 8'hFF);
    rd(4'd4, 4'd1, rv); chk("chmask_lane1", rv, 8'hFF);

    // Reprogram DELAY mid-run: current run keeps 10, next armed run uses 100.
    v = '{d:10, w:1, g:0, r:0, mask:1, mode:0, src:0, exp_first:0, exp_done:0, exp_fc:0};
    i_trig = 1'b0;
    program_cfg(v);
    arm = 1'b1; tick(); arm = 1'b0;
    rd(4'd7, 4'd0, rv); chk("status_armed", rv, 1);
    rd(4'd0, 4'd0, rv); chk("delay_readback", rv, 10);
    sw_fire(e);
    wr(4'd0, 4'd0, 8'd100);
    wait_first(e, 200, first); chk("reprog_old_delay", first, 11);
    wait_done(50, ok); chk("reprog_done1", ok, 1);
    arm = 1'b1; tick(); arm = 1'b0;
    sw_fire(e);
    wait_first(e, 300, first); chk("reprog_new_delay", first, 101);
    wait_done(50, ok); chk("reprog_done2", ok, 1);

    // disarm beats a simultaneous arm while firing.
    v = '{d:0, w:5, g:0, r:0, mask:15, mode:0, src:0, exp_first:0, exp_done:0, exp_fc:0};
    program_cfg(v);
    arm = 1'b1; tick(); arm = 1'b0;
    sw_fire(e);
    chk("dis_firing", int'(o_glitch), 15);
    arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
    chk("dis_glitch", int'(o_glitch), 0);
    chk("dis_state", int'(o_state), 0);
    repeat (3) tick();
    chk("dis_state_hold", int'(o_state), 0);
    chk("dis_no_done", int'(o_done), 0);

    for (int i = 0; i < 30; i++) begin
      v.d = $urandom_range(0, 6); v.w = $urandom_range(0, 4); v.g = $urandom_range(0, 4);
      v.r = $urandom_range(0, 3); v.mask = $urandom_range(0, 15); v.mode = $urandom_range(0, 7);
      v.src = $urandom_range(0, 1);
      run(v, first, done_t);
      chk("rand_done_t", done_t, run_end(v));
    end

    // Reset mid-pulse clears outputs and configuration.
    v = '{d:0, w:4, g:0, r:0, mask:15, mode:0, src:0, exp_first:0, exp_done:0, exp_fc:0};
    program_cfg(v);
    arm = 1'b1; tick(); arm = 1'b0;
    sw_fire(e);
    chk("pre_rst_glitch", int'(o_glitch), 15);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_glitch", int'(o_glitch), 0);
    chk("mid_rst_state", int'(o_state), 0);
    chk("mid_rst_fc", int'(o_fire_count), 0);
    rd(4'd1, 4'd0, rv); chk("mid_rst_width", rv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
